// File: rtl/mult_display_ctrl.sv
// mult_display_ctrl: sequences signed multiply, BCD conversion, load and bounded scroll of the digit register.
module mult_display_ctrl #(
    parameter int WIDTH      = 8,
    parameter int BCD_DIGITS = 5,
    parameter int WINDOW     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIDTH-1:0]        a_in,
    input  logic [WIDTH-1:0]        b_in,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    mul_done,
    input  logic [2*WIDTH-1:0]      mul_product,
    input  logic [4*BCD_DIGITS-1:0] bcd_in,
    output logic [WIDTH-1:0]        mag_a,
    output logic [WIDTH-1:0]        mag_b,
    output logic                    mul_start,
    output logic [2*WIDTH-1:0]      bin_out,
    output logic                    sr_load,
    output logic                    sr_en,
    output logic                    sr_dir,
    output logic                    neg,
    output logic [2:0]              scroll_pos,
    output logic                    busy,
    output logic                    valid
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MUL  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] CONV = 3'd3;
    localparam logic [2:0] LOAD = 3'd4;
    localparam logic [2:0] SHOW = 3'd5;
    localparam logic [2:0] MAX_POS = 3'(BCD_DIGITS - WINDOW);

    logic [2:0] state, nxt;
    logic       s, take, go_left, go_right;

    assign take     = start && (state == IDLE || state == SHOW);
    assign go_left  = state == SHOW && !start && btn_left && !btn_right && scroll_pos < MAX_POS;
    assign go_right = state == SHOW && !start && btn_right && !btn_left && scroll_pos != 3'd0;

    // mul_done is only looked at in WAIT, so a stuck-high flag still costs one WAIT cycle
    always_comb begin
        nxt = take ? MUL :
              state == MUL  ? WAIT :
              state == WAIT ? (mul_done ? CONV : WAIT) :
              state == CONV ? LOAD :
              state == LOAD ? SHOW :
              state == SHOW ? SHOW : IDLE;
    end

    // every output is registered off the next state so nothing reaches an output combinationally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mag_a      <= '0;
            mag_b      <= '0;
            s          <= 1'b0;
            bin_out    <= '0;
            neg        <= 1'b0;
            scroll_pos <= '0;
            mul_start  <= 1'b0;
            sr_load    <= 1'b0;
            sr_en      <= 1'b0;
            sr_dir     <= 1'b0;
            busy       <= 1'b0;
            valid      <= 1'b0;
        end else begin
            state     <= nxt;
            mul_start <= nxt == MUL;
            sr_load   <= nxt == LOAD;
            busy      <= nxt == MUL || nxt == WAIT || nxt == CONV || nxt == LOAD;
            valid     <= nxt == SHOW;
            sr_en     <= go_left || go_right;
            sr_dir    <= go_right;
            if (take) begin
                mag_a <= a_in[WIDTH-1] ? WIDTH'(-a_in) : a_in;
                mag_b <= b_in[WIDTH-1] ? WIDTH'(-b_in) : b_in;
                s     <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            end
            if (state == WAIT && mul_done) begin
                bin_out <= mul_product;
                neg     <= s && mul_product != '0;
            end
            if (state == LOAD)
                scroll_pos <= '0;
            else if (go_left)
                scroll_pos <= scroll_pos + 3'd1;
            else if (go_right)
                scroll_pos <= scroll_pos - 3'd1;
        end
    end
endmodule
